deselector: RTL and testbench



---
 rtl/deselector_pkg.sv | 22 ++
 rtl/deselector_if.sv | 26 ++
 rtl/deselector_bit_demux_reg.sv | 30 +++
 rtl/deselector.sv | 96 +++++++++
 tb/tb_deselector.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/deselector_pkg.sv
// Shared constants and types for the deselector: position codes, FSM states,
// and the assembled word width.
`timescale 1ns/1ps
package deselector_pkg;

   localparam int WORD_W = 4;

   localparam logic [1:0] POS0 = 2'd0;
   localparam logic [1:0] POS1 = 2'd1;
   localparam logic [1:0] POS2 = 2'd2;
   localparam logic [1:0] POS3 = 2'd3;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   function automatic logic [WORD_W-1:0] pos_onehot(input logic [1:0] pos);
      return WORD_W'(1) << pos;
   endfunction

endpackage

// File: rtl/deselector_if.sv
// Write/observe bundle for the deselector; master drives writes, slave is the DUT.
`timescale 1ns/1ps
interface deselector_if;
   logic       wr;
   logic       auto;
   logic       s0;
   logic       s1;
   logic       in1;
   logic       in2;
   logic       ack;
   logic [3:0] out1;
   logic [3:0] out2;
   logic       valid;
   logic       ready;
   logic [1:0] ptr;

   modport master (
      output wr, auto, s0, s1, in1, in2, ack,
      input  out1, out2, valid, ready, ptr
   );

   modport slave (
      input  wr, auto, s0, s1, in1, in2, ack,
      output out1, out2, valid, ready, ptr
   );
endinterface

// File: rtl/deselector_bit_demux_reg.sv
// One lane: 4-bit register where each bit loads the serial input on its own enable.
`timescale 1ns/1ps
module deselector_bit_demux_reg
   import deselector_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WORD_W-1:0] i_we,
   input  logic              i_clr,
   input  logic              i_din,
   output logic [WORD_W-1:0] o_q
);

   logic [WORD_W-1:0] r_q;

   // A write wins over clear so an ack+wr frame start keeps its first bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= '0;
      end else begin
         for (int b = 0; b < WORD_W; b++) begin
            if (i_we[b])    r_q[b] <= i_din;
            else if (i_clr) r_q[b] <= 1'b0;
         end
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/deselector.sv
// Registered 1-to-4 bit demultiplexer: assembles two 4-bit words from serial
// writes, flags a full frame with valid and releases it on ack.
`timescale 1ns/1ps
module deselector
   import deselector_pkg::*;
#(
   parameter bit CLEAR_ON_ACK = 1'b0
) (
   input logic         clk,
   input logic         rst_n,
   deselector_if.slave bus
);

   state_t            r_state, w_state_nxt;
   logic [WORD_W-1:0] r_mask,  w_mask_nxt;
   logic [1:0]        r_ptr,   w_ptr_nxt;
   logic [1:0]        w_pos;
   logic [WORD_W-1:0] w_sel;
   logic [WORD_W-1:0] w_we;
   logic              w_clr;

   // A write accepted with ack starts a new frame, so auto mode targets position 0.
   always_comb begin
      w_pos = {bus.s1, bus.s0};
      if (bus.auto) w_pos = (r_state == ST_HOLD) ? POS0 : r_ptr;
   end

   assign w_sel = pos_onehot(w_pos);

   always_comb begin
      w_state_nxt = r_state;
      w_mask_nxt  = r_mask;
      w_ptr_nxt   = r_ptr;
      w_we        = '0;
      w_clr       = 1'b0;
      unique case (r_state)
         ST_FILL: begin
            if (bus.wr) begin
               w_we       = w_sel;
               w_mask_nxt = r_mask | w_sel;
               if (bus.auto) w_ptr_nxt = r_ptr + 2'd1;
               if (w_mask_nxt == '1) w_state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (bus.ack) begin
               w_state_nxt = ST_FILL;
               w_mask_nxt  = '0;
               w_ptr_nxt   = POS0;
               w_clr       = CLEAR_ON_ACK;
               if (bus.wr) begin
                  w_we       = w_sel;
                  w_mask_nxt = w_sel;
                  if (bus.auto) w_ptr_nxt = POS1;
               end
            end
         end
         default: w_state_nxt = ST_FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_FILL;
         r_mask  <= '0;
         r_ptr   <= POS0;
      end else begin
         r_state <= w_state_nxt;
         r_mask  <= w_mask_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   deselector_bit_demux_reg u_lane1 (
      .clk   (clk),
      .rst_n (rst_n),
      .i_we  (w_we),
      .i_clr (w_clr),
      .i_din (bus.in1),
      .o_q   (bus.out1)
   );

   deselector_bit_demux_reg u_lane2 (
      .clk   (clk),
      .rst_n (rst_n),
      .i_we  (w_we),
      .i_clr (w_clr),
      .i_din (bus.in2),
      .o_q   (bus.out2)
   );

   assign bus.valid = (r_state == ST_HOLD);
   assign bus.ready = (r_state != ST_HOLD);
   assign bus.ptr   = r_ptr;

endmodule

// File: tb/tb_deselector.sv
// Directed bench for deselector: one instance retaining data on ack, one clearing.
`timescale 1ns/1ps
module tb_deselector;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   deselector_if if0 ();
   deselector_if if1 ();

   deselector #(.CLEAR_ON_ACK(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
   deselector #(.CLEAR_ON_ACK(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock with the given dut0 inputs, then back to idle; sampling point is #1 after the edge.
   task automatic cyc0(input logic w, input logic a, input logic [1:0] p,
                       input logic d1, input logic d2, input logic k);
      if0.wr = w; if0.auto = a; if0.s1 = p[1]; if0.s0 = p[0];
      if0.in1 = d1; if0.in2 = d2; if0.ack = k;
      @(posedge clk); #1;
      if0.wr = 1'b0; if0.ack = 1'b0;
   endtask

   task automatic cyc1(input logic w, input logic d1, input logic d2, input logic k);
      if1.wr = w; if1.auto = 1'b1; if1.s1 = 1'b0; if1.s0 = 1'b0;
      if1.in1 = d1; if1.in2 = d2; if1.ack = k;
      @(posedge clk); #1;
      if1.wr = 1'b0; if1.ack = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      if0.wr = 0; if0.auto = 0; if0.s0 = 0; if0.s1 = 0; if0.in1 = 0; if0.in2 = 0; if0.ack = 0;
      if1.wr = 0; if1.auto = 0; if1.s0 = 0; if1.s1 = 0; if1.in1 = 0; if1.in2 = 0; if1.ack = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out1", 8'(if0.out1), 8'h0);
      chk("rst_valid", 8'(if0.valid), 8'h0);
      chk("rst_ready", 8'(if0.ready), 8'h1);
      rst_n = 1'b1;

      // Partial auto frame, then asynchronous reset mid-cycle
      cyc0(1, 1, 2'd0, 1, 1, 0);
      cyc0(1, 1, 2'd0, 1, 1, 0);
      chk("part_out1", 8'(if0.out1), 8'h3);
      chk("part_ptr", 8'(if0.ptr), 8'h2);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out1", 8'(if0.out1), 8'h0);
      chk("arst_out2", 8'(if0.out2), 8'h0);
      chk("arst_valid", 8'(if0.valid), 8'h0);
      chk("arst_ready", 8'(if0.ready), 8'h1);
      chk("arst_ptr", 8'(if0.ptr), 8'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Manual fill of positions 0..3
      cyc0(1, 0, 2'd0, 0, 0, 0);
      cyc0(1, 0, 2'd1, 1, 0, 0);
      cyc0(1, 0, 2'd2, 0, 1, 0);
      chk("man3_valid", 8'(if0.valid), 8'h0);
      cyc0(1, 0, 2'd3, 1, 1, 0);
      chk("man_out1", 8'(if0.out1), 8'hA);
      chk("man_out2", 8'(if0.out2), 8'hC);
      chk("man_valid", 8'(if0.valid), 8'h1);
      chk("man_ready", 8'(if0.ready), 8'h0);
      cyc0(1, 0, 2'd0, 1, 1, 0);
      chk("hold_wr_out1", 8'(if0.out1), 8'hA);
      chk("hold_wr_out2", 8'(if0.out2), 8'hC);
      cyc0(0, 0, 2'd0, 0, 0, 1);
      chk("ack_valid", 8'(if0.valid), 8'h0);
      chk("ack_keep_out1", 8'(if0.out1), 8'hA);

      // Duplicate positions 2,2,0,1 then 3
      cyc0(1, 0, 2'd2, 1, 0, 0);
      cyc0(1, 0, 2'd2, 0, 0, 0);
      cyc0(1, 0, 2'd0, 1, 0, 0);
      cyc0(1, 0, 2'd1, 1, 0, 0);
      chk("dup_valid", 8'(if0.valid), 8'h0);
      chk("dup_mask", 8'(dut0.r_mask), 8'h7);
      cyc0(1, 0, 2'd3, 1, 0, 0);
      chk("dup_valid4", 8'(if0.valid), 8'h1);
      chk("dup_out1", 8'(if0.out1), 8'hB);
      chk("dup_out2", 8'(if0.out2), 8'h0);
      cyc0(0, 0, 2'd0, 0, 0, 1);

      // Auto wrap with in1 = 1,1,0,1
      cyc0(1, 1, 2'd0, 1, 0, 0);
      chk("auto_ptr1", 8'(if0.ptr), 8'h1);
      cyc0(1, 1, 2'd0, 1, 0, 0);
      chk("auto_ptr2", 8'(if0.ptr), 8'h2);
      cyc0(1, 1, 2'd0, 0, 0, 0);
      chk("auto_ptr3", 8'(if0.ptr), 8'h3);
      cyc0(1, 1, 2'd0, 1, 0, 0);
      chk("auto_ptr0", 8'(if0.ptr), 8'h0);
      chk("auto_out1", 8'(if0.out1), 8'hB);
      chk("auto_valid", 8'(if0.valid), 8'h1);
      cyc0(1, 1, 2'd0, 0, 0, 0);
      chk("auto_hold_out1", 8'(if0.out1), 8'hB);
      chk("auto_hold_ptr", 8'(if0.ptr), 8'h0);
      cyc0(0, 1, 2'd0, 0, 0, 1);
      chk("auto_ack_valid", 8'(if0.valid), 8'h0);
      chk("auto_ack_out1", 8'(if0.out1), 8'hB);

      // Full 1111 frame, then ack+wr at auto position 0 with in1=0
      repeat (4) cyc0(1, 1, 2'd0, 1, 0, 0);
      chk("f2_out1", 8'(if0.out1), 8'hF);
      chk("f2_valid", 8'(if0.valid), 8'h1);
      cyc0(1, 1, 2'd0, 0, 0, 1);
      chk("ackwr_valid", 8'(if0.valid), 8'h0);
      chk("ackwr_out1", 8'(if0.out1), 8'hE);
      chk("ackwr_mask", 8'(dut0.r_mask), 8'h1);
      chk("ackwr_ptr", 8'(if0.ptr), 8'h1);
      cyc0(0, 1, 2'd0, 0, 0, 1);
      chk("fill_ack_mask", 8'(dut0.r_mask), 8'h1);
      chk("fill_ack_valid", 8'(if0.valid), 8'h0);
      cyc0(1, 0, 2'd3, 1, 0, 0);
      chk("man_noptr", 8'(if0.ptr), 8'h1);
      chk("man_mask", 8'(dut0.r_mask), 8'h9);
      cyc0(1, 1, 2'd0, 0, 0, 0);
      cyc0(1, 1, 2'd0, 0, 0, 0);
      chk("mix_valid", 8'(if0.valid), 8'h1);
      chk("mix_out1", 8'(if0.out1), 8'h8);
      chk("mix_ptr", 8'(if0.ptr), 8'h3);

      // Clearing instance
      repeat (4) cyc1(1, 1, 1, 0);
      chk("clr_full_out1", 8'(if1.out1), 8'hF);
      chk("clr_full_valid", 8'(if1.valid), 8'h1);
      cyc1(0, 0, 0, 1);
      chk("clr_out1", 8'(if1.out1), 8'h0);
      chk("clr_out2", 8'(if1.out2), 8'h0);
      chk("clr_valid", 8'(if1.valid), 8'h0);
      repeat (4) cyc1(1, 1, 1, 0);
      cyc1(1, 1, 0, 1);
      chk("clrwr_out1", 8'(if1.out1), 8'h1);
      chk("clrwr_out2", 8'(if1.out2), 8'h0);
      chk("clrwr_ptr", 8'(if1.ptr), 8'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
